// File: rtl/cpu_dmem_arbiter_if.sv
// Requester-side and Wishbone data-bus signals of cpu_dmem_arbiter.
// Names and directions are given from the arbiter's point of view.
interface cpu_dmem_arbiter_if;
   logic        req0_req_i;
   logic        req0_we_i;
   logic [31:0] req0_addr_i;
   logic [1:0]  req0_size_i;
   logic [31:0] req0_wdata_i;
   logic        req0_ack_o;
   logic        req0_err_o;
   logic [31:0] req0_rdata_o;

   logic        req1_req_i;
   logic        req1_we_i;
   logic [31:0] req1_addr_i;
   logic [1:0]  req1_size_i;
   logic [31:0] req1_wdata_i;
   logic        req1_ack_o;
   logic        req1_err_o;
   logic [31:0] req1_rdata_o;

   logic [31:0] dmem_adr_o;
   logic [15:0] dmem_dat_o;
   logic [15:0] dmem_dat_i;
   logic [1:0]  dmem_sel_o;
   logic        dmem_we_o;
   logic        dmem_stb_o;
   logic        dmem_cyc_o;
   logic        dmem_ack_i;
   logic        dmem_err_i;
   logic [1:0]  grant_o;

   // Arbiter side: serves the requesters and masters the data bus.
   modport master (
      input  req0_req_i, req0_we_i, req0_addr_i, req0_size_i, req0_wdata_i,
      output req0_ack_o, req0_err_o, req0_rdata_o,
      input  req1_req_i, req1_we_i, req1_addr_i, req1_size_i, req1_wdata_i,
      output req1_ack_o, req1_err_o, req1_rdata_o,
      output dmem_adr_o, dmem_dat_o, dmem_sel_o, dmem_we_o, dmem_stb_o, dmem_cyc_o,
      input  dmem_dat_i, dmem_ack_i, dmem_err_i,
      output grant_o
   );

   // Environment side: requesters plus the bus slave.
   modport slave (
      output req0_req_i, req0_we_i, req0_addr_i, req0_size_i, req0_wdata_i,
      input  req0_ack_o, req0_err_o, req0_rdata_o,
      output req1_req_i, req1_we_i, req1_addr_i, req1_size_i, req1_wdata_i,
      input  req1_ack_o, req1_err_o, req1_rdata_o,
      input  dmem_adr_o, dmem_dat_o, dmem_sel_o, dmem_we_o, dmem_stb_o, dmem_cyc_o,
      output dmem_dat_i, dmem_ack_i, dmem_err_i,
      input  grant_o
   );
endinterface

// File: rtl/cpu_dmem_arbiter.sv
// Two-port round-robin data-memory arbiter onto a 16-bit Wishbone bus.
// Splits long accesses into two big-endian beats, steers byte lanes, reports errors/timeouts.
module cpu_dmem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,
   cpu_dmem_arbiter_if.master bus
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_SHORT = 2'b01;
   localparam logic [1:0] SZ_LONG  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

   state_t        state_q, state_d;
   logic          rr_q, rr_d;
   logic          own_q, own_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    size_q, size_d;
   logic [AW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] hi_q, hi_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          cyc_q, cyc_d;
   logic          stb_q, stb_d;
   logic          bus_we_q, bus_we_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] dat_q, dat_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    grant_q, grant_d;
   logic [1:0]    ack_q, ack_d;
   logic [1:0]    err_q, err_d;
   logic [AW-1:0] rdata0_q, rdata0_d;
   logic [AW-1:0] rdata1_q, rdata1_d;

   logic          fail_c;
   logic [AW-1:0] res_c;
   logic          beat_c;

   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_BYTE:  return 1'b0;
         SZ_SHORT: return a[0];
         SZ_LONG:  return a != 2'b00;
         default:  return 1'b1;
      endcase
   endfunction

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         rr_q     <= 1'b0;
         own_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
         wdata_q  <= '0;
         hi_q     <= '0;
         cnt_q    <= '0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         bus_we_q <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         grant_q  <= '0;
         ack_q    <= '0;
         err_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         own_q    <= own_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         wdata_q  <= wdata_d;
         hi_q     <= hi_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         stb_q    <= stb_d;
         bus_we_q <= bus_we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Next state, request latch and beat bookkeeping.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      own_d   = own_q;
      we_d    = we_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      fail_c  = 1'b0;
      res_c   = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.req0_req_i || bus.req1_req_i) begin
               // rr_q names the favoured port when both are requesting.
               own_d = bus.req1_req_i && (!bus.req0_req_i || rr_q);
               if (own_d) begin
                  we_d    = bus.req1_we_i;
                  addr_d  = bus.req1_addr_i;
                  size_d  = bus.req1_size_i;
                  wdata_d = bus.req1_wdata_i;
               end else begin
                  we_d    = bus.req0_we_i;
                  addr_d  = bus.req0_addr_i;
                  size_d  = bus.req0_size_i;
                  wdata_d = bus.req0_wdata_i;
               end
               cnt_d = '0;
               if (misaligned(size_d, addr_d[1:0])) begin
                  state_d = S_RESP;
                  fail_c  = 1'b1;
               end else begin
                  state_d = S_BEAT0;
               end
            end
         end
         S_BEAT0, S_BEAT1: begin
            if (bus.dmem_err_i) begin
               state_d = S_RESP;
               fail_c  = 1'b1;
            end else if (bus.dmem_ack_i) begin
               if (state_q == S_BEAT0 && size_q == SZ_LONG) begin
                  state_d = S_BEAT1;
                  hi_d    = bus.dmem_dat_i;
                  cnt_d   = '0;
               end else begin
                  state_d = S_RESP;
                  case (size_q)
                     SZ_BYTE:  res_c = {24'h0, addr_q[0] ? bus.dmem_dat_i[7:0] : bus.dmem_dat_i[15:8]};
                     SZ_SHORT: res_c = {16'h0, bus.dmem_dat_i};
                     default:  res_c = {hi_q, bus.dmem_dat_i};
                  endcase
               end
            end else if (cnt_q == TO_LAST) begin
               state_d = S_RESP;
               fail_c  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            rr_d    = ~own_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered bus and response outputs, derived from the upcoming state.
   always_comb begin
      beat_c   = (state_d == S_BEAT0) || (state_d == S_BEAT1);
      cyc_d    = beat_c;
      stb_d    = beat_c;
      bus_we_d = beat_c && we_d;
      adr_d    = '0;
      dat_d    = '0;
      sel_d    = '0;
      grant_d  = '0;
      ack_d    = '0;
      err_d    = '0;
      rdata0_d = '0;
      rdata1_d = '0;

      if (beat_c) begin
         adr_d = (state_d == S_BEAT1) ? addr_d + AW'(2) : {addr_d[AW-1:1], 1'b0};
         case (size_d)
            SZ_BYTE: begin
               sel_d = addr_d[0] ? 2'b01 : 2'b10;
               dat_d = {wdata_d[7:0], wdata_d[7:0]};
            end
            SZ_SHORT: begin
               sel_d = 2'b11;
               dat_d = wdata_d[15:0];
            end
            default: begin
               sel_d = 2'b11;
               dat_d = (state_d == S_BEAT1) ? wdata_d[15:0] : wdata_d[31:16];
            end
         endcase
      end

      if (state_d != S_IDLE) grant_d[own_d] = 1'b1;

      if (state_d == S_RESP) begin
         ack_d[own_d] = 1'b1;
         err_d[own_d] = fail_c;
         if (!fail_c) begin
            if (own_d) rdata1_d = res_c;
            else       rdata0_d = res_c;
         end
      end
   end

   assign bus.dmem_cyc_o   = cyc_q;
   assign bus.dmem_stb_o   = stb_q;
   assign bus.dmem_we_o    = bus_we_q;
   assign bus.dmem_adr_o   = adr_q;
   assign bus.dmem_dat_o   = dat_q;
   assign bus.dmem_sel_o   = sel_q;
   assign bus.grant_o      = grant_q;
   assign bus.req0_ack_o   = ack_q[0];
   assign bus.req1_ack_o   = ack_q[1];
   assign bus.req0_err_o   = err_q[0];
   assign bus.req1_err_o   = err_q[1];
   assign bus.req0_rdata_o = rdata0_q;
   assign bus.req1_rdata_o = rdata1_q;
endmodule

// File: tb/tb_cpu_dmem_arbiter.sv
// Self-checking bench for cpu_dmem_arbiter: table of single accesses plus reset and
// arbitration sequences, with beat and response scoreboards fed at stimulus time.
module tb_cpu_dmem_arbiter;
   localparam int unsigned TO = 4;

   typedef struct {
      logic [31:0] adr;
      logic [1:0]  sel;
      logic        we;
      logic [15:0] dat;
   } beat_t;

   typedef struct {
      int          port;
      logic        err;
      logic [31:0] rdata;
      logic        chk_rd;
   } resp_t;

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [15:0] d0;
      logic [15:0] d1;
      int          wt;
      int          eb;
      logic        exp_err;
      logic [31:0] exp_rd;
      int          nb;
      logic [31:0] adr0;
      logic [31:0] adr1;
      logic [1:0]  sel;
      logic [15:0] dat0;
      logic [15:0] dat1;
      int          lat;
      int          nstb;
   } vec_t;

   logic clk_i = 1'b0;
   logic rst_n;
   always #5 clk_i = ~clk_i;

   cpu_dmem_arbiter_if bus_if ();
   cpu_dmem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i (clk_i),
      .rst_i (rst_n),
      .bus   (bus_if)
   );

   int total = 0;
   int bad   = 0;
   beat_t beat_q[$];
   resp_t resp_q[$];
   int stb_cnt = 0;

   // Bus slave: acks after slv_wait wait states; on beat slv_eb it raises err together with ack.
   logic [15:0] slv_d0 = 16'h0;
   logic [15:0] slv_d1 = 16'h0;
   int slv_wait = 0;
   int slv_eb = -1;
   int slv_wcnt;
   int slv_beat;
   logic slv_hit;
   assign slv_hit = bus_if.dmem_stb_o && (slv_wcnt == slv_wait);
   assign bus_if.dmem_ack_i = slv_hit;
   assign bus_if.dmem_err_i = slv_hit && (slv_beat == slv_eb);
   assign bus_if.dmem_dat_i = (slv_beat == 0) ? slv_d0 : slv_d1;

   always @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         slv_wcnt <= 0;
         slv_beat <= 0;
      end else if (!bus_if.dmem_cyc_o) begin
         slv_wcnt <= 0;
         slv_beat <= 0;
      end else if (slv_hit) begin
         slv_wcnt <= 0;
         slv_beat <= slv_beat + 1;
      end else if (bus_if.dmem_stb_o) begin
         slv_wcnt <= slv_wcnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_evt(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %h want nothing (t=%0t)", name, act, $time);
   endtask

   // Monitor: pops expected beats on each bus handshake and expected responses on each ack.
   always @(negedge clk_i) begin
      beat_t b;
      resp_t r;
      logic [1:0] acks;
      logic [1:0] errs;
      logic [31:0] rd;
      if (bus_if.dmem_stb_o) stb_cnt++;
      if (bus_if.dmem_stb_o && (bus_if.dmem_ack_i || bus_if.dmem_err_i)) begin
         if (beat_q.size() == 0) fail_evt("unexpected_beat", bus_if.dmem_adr_o);
         else begin
            b = beat_q.pop_front();
            chk("beat_adr", bus_if.dmem_adr_o, b.adr);
            chk("beat_sel", 32'(bus_if.dmem_sel_o), 32'(b.sel));
            chk("beat_we", 32'(bus_if.dmem_we_o), 32'(b.we));
            chk("beat_dat", 32'(bus_if.dmem_dat_o), 32'(b.dat));
         end
      end
      acks = {bus_if.req1_ack_o, bus_if.req0_ack_o};
      errs = {bus_if.req1_err_o, bus_if.req0_err_o};
      if (acks == 2'b11) fail_evt("double_ack", 32'(acks));
      for (int p = 0; p < 2; p++) begin
         if (errs[p] && !acks[p]) fail_evt("err_without_ack", 32'(p));
         if (acks[p]) begin
            rd = (p == 0) ? bus_if.req0_rdata_o : bus_if.req1_rdata_o;
            if (resp_q.size() == 0) fail_evt("unexpected_ack", 32'(p));
            else begin
               r = resp_q.pop_front();
               chk("ack_port", 32'(p), 32'(r.port));
               chk("ack_err", 32'(errs[p]), 32'(r.err));
               chk("ack_grant", 32'(bus_if.grant_o), (p == 0) ? 32'h1 : 32'h2);
               if (r.chk_rd) chk("ack_rdata", rd, r.rdata);
            end
         end
      end
   end

   task automatic drive(input int p, input logic rq, input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd);
      if (p == 0) begin
         bus_if.req0_req_i = rq; bus_if.req0_we_i = we; bus_if.req0_addr_i = a;
         bus_if.req0_size_i = sz; bus_if.req0_wdata_i = wd;
      end else begin
         bus_if.req1_req_i = rq; bus_if.req1_we_i = we; bus_if.req1_addr_i = a;
         bus_if.req1_size_i = sz; bus_if.req1_wdata_i = wd;
      end
   endtask

   function automatic logic port_ack(input int p);
      return (p == 0) ? bus_if.req0_ack_o : bus_if.req1_ack_o;
   endfunction

   task automatic push_beat(input logic [31:0] a, input logic [1:0] s, input logic w, input logic [15:0] d);
      beat_t b;
      b.adr = a; b.sel = s; b.we = w; b.dat = d;
      beat_q.push_back(b);
   endtask

   task automatic push_resp(input int p, input logic e, input logic [31:0] rd, input logic c);
      resp_t r;
      r.port = p; r.err = e; r.rdata = rd; r.chk_rd = c;
      resp_q.push_back(r);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      int base;
      logic seen;
      @(negedge clk_i);
      slv_d0 = v.d0; slv_d1 = v.d1; slv_wait = v.wt; slv_eb = v.eb;
      for (int i = 0; i < v.nb; i++)
         push_beat((i == 0) ? v.adr0 : v.adr1, v.sel, v.we, (i == 0) ? v.dat0 : v.dat1);
      push_resp(v.port, v.exp_err, v.exp_rd, !v.we || v.exp_err);
      base = stb_cnt;
      drive(v.port, 1'b1, v.we, v.addr, v.size, v.wdata);
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk_i);
         lat++;
         seen = port_ack(v.port);
      end
      chk("ack_seen", 32'(seen), 32'h1);
      chk("latency", 32'(lat), 32'(v.lat));
      chk("stb_cycles", 32'(stb_cnt - base), 32'(v.nstb));
      drive(v.port, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
   endtask

   vec_t vecs[15];

   initial begin
      int acks;
      int cyc;
      vecs[0]  = '{0, 1'b1, 32'h100, 2'b10, 32'h11223344, 16'h0, 16'h0, 0, -1, 1'b0, 32'h0, 2,
                   32'h100, 32'h102, 2'b11, 16'h1122, 16'h3344, 3, 2};
      vecs[1]  = '{0, 1'b0, 32'h201, 2'b00, 32'h0, 16'hAB5C, 16'h0, 0, -1, 1'b0, 32'h5C, 1,
                   32'h200, 32'h0, 2'b01, 16'h0, 16'h0, 2, 1};
      vecs[2]  = '{1, 1'b0, 32'h200, 2'b00, 32'h0, 16'hAB5C, 16'h0, 0, -1, 1'b0, 32'hAB, 1,
                   32'h200, 32'h0, 2'b10, 16'h0, 16'h0, 2, 1};
      vecs[3]  = '{1, 1'b1, 32'h203, 2'b00, 32'h000000A7, 16'h0, 16'h0, 0, -1, 1'b0, 32'h0, 1,
                   32'h202, 32'h0, 2'b01, 16'hA7A7, 16'h0, 2, 1};
      vecs[4]  = '{0, 1'b0, 32'h402, 2'b01, 32'h0, 16'hBEEF, 16'h0, 2, -1, 1'b0, 32'hBEEF, 1,
                   32'h402, 32'h0, 2'b11, 16'h0, 16'h0, 4, 3};
      vecs[5]  = '{1, 1'b1, 32'h1000, 2'b01, 32'h0000CAFE, 16'h0, 16'h0, 0, -1, 1'b0, 32'h0, 1,
                   32'h1000, 32'h0, 2'b11, 16'hCAFE, 16'h0, 2, 1};
      vecs[6]  = '{1, 1'b0, 32'h300, 2'b10, 32'h0, 16'h1234, 16'h5678, 1, -1, 1'b0, 32'h12345678, 2,
                   32'h300, 32'h302, 2'b11, 16'h0, 16'h0, 5, 4};
      vecs[7]  = '{0, 1'b0, 32'h500, 2'b10, 32'h0, 16'h9999, 16'h8888, 0, 0, 1'b1, 32'h0, 1,
                   32'h500, 32'h0, 2'b11, 16'h0, 16'h0, 2, 1};
      vecs[8]  = '{0, 1'b0, 32'h3, 2'b01, 32'h0, 16'h0, 16'h0, 0, -1, 1'b1, 32'h0, 0,
                   32'h0, 32'h0, 2'b00, 16'h0, 16'h0, 1, 0};
      vecs[9]  = '{1, 1'b1, 32'h102, 2'b10, 32'h55, 16'h0, 16'h0, 0, -1, 1'b1, 32'h0, 0,
                   32'h0, 32'h0, 2'b00, 16'h0, 16'h0, 1, 0};
      vecs[10] = '{0, 1'b0, 32'h0, 2'b11, 32'h0, 16'h0, 16'h0, 0, -1, 1'b1, 32'h0, 0,
                   32'h0, 32'h0, 2'b00, 16'h0, 16'h0, 1, 0};
      vecs[11] = '{1, 1'b1, 32'hFFFFFFFC, 2'b10, 32'hDEADBEEF, 16'h0, 16'h0, 0, -1, 1'b0, 32'h0, 2,
                   32'hFFFFFFFC, 32'hFFFFFFFE, 2'b11, 16'hDEAD, 16'hBEEF, 3, 2};
      vecs[12] = '{1, 1'b0, 32'h600, 2'b10, 32'h0, 16'h1111, 16'h2222, 0, 1, 1'b1, 32'h0, 2,
                   32'h600, 32'h602, 2'b11, 16'h0, 16'h0, 3, 2};
      vecs[13] = '{0, 1'b0, 32'h700, 2'b01, 32'h0, 16'h0001, 16'h0, 99, -1, 1'b1, 32'h0, 0,
                   32'h0, 32'h0, 2'b00, 16'h0, 16'h0, 5, 4};
      vecs[14] = '{1, 1'b0, 32'h704, 2'b01, 32'h0, 16'h7E57, 16'h0, 3, -1, 1'b0, 32'h7E57, 1,
                   32'h704, 32'h0, 2'b11, 16'h0, 16'h0, 5, 4};

      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
      #12;
      chk("rst_ack0", 32'(bus_if.req0_ack_o), 32'h0);
      chk("rst_ack1", 32'(bus_if.req1_ack_o), 32'h0);
      chk("rst_err0", 32'(bus_if.req0_err_o), 32'h0);
      chk("rst_err1", 32'(bus_if.req1_err_o), 32'h0);
      chk("rst_rdata0", bus_if.req0_rdata_o, 32'h0);
      chk("rst_rdata1", bus_if.req1_rdata_o, 32'h0);
      chk("rst_grant", 32'(bus_if.grant_o), 32'h0);
      chk("rst_cyc", 32'(bus_if.dmem_cyc_o), 32'h0);
      chk("rst_stb", 32'(bus_if.dmem_stb_o), 32'h0);
      chk("rst_we", 32'(bus_if.dmem_we_o), 32'h0);
      chk("rst_adr", bus_if.dmem_adr_o, 32'h0);
      chk("rst_dat", 32'(bus_if.dmem_dat_o), 32'h0);
      chk("rst_sel", 32'(bus_if.dmem_sel_o), 32'h0);
      @(negedge clk_i);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) run_vec(vecs[i]);

      // Reset while a long write sits in its second beat: bus drops at once, no ack.
      @(negedge clk_i);
      slv_wait = 2; slv_eb = -1; slv_d0 = 16'h0;
      push_beat(32'h800, 2'b11, 1'b1, 16'hA1B2);
      drive(0, 1'b1, 1'b1, 32'h800, 2'b10, 32'hA1B2C3D4);
      repeat (4) @(negedge clk_i);
      chk("beat1_adr", bus_if.dmem_adr_o, 32'h802);
      chk("beat1_dat", 32'(bus_if.dmem_dat_o), 32'hC3D4);
      chk("beat1_cyc", 32'(bus_if.dmem_cyc_o), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("arst_cyc", 32'(bus_if.dmem_cyc_o), 32'h0);
      chk("arst_stb", 32'(bus_if.dmem_stb_o), 32'h0);
      chk("arst_grant", 32'(bus_if.grant_o), 32'h0);
      drive(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
      repeat (2) @(negedge clk_i);
      rst_n = 1'b1;

      // Both ports request continuously: owners must alternate starting at port 0.
      @(negedge clk_i);
      slv_wait = 0; slv_d0 = 16'h4242;
      for (int k = 0; k < 4; k++) begin
         push_beat((k % 2 == 0) ? 32'h10 : 32'h20, 2'b11, 1'b0, 16'h0);
         push_resp(k % 2, 1'b0, 32'h4242, 1'b1);
      end
      drive(0, 1'b1, 1'b0, 32'h10, 2'b01, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h20, 2'b01, 32'h0);
      @(negedge clk_i);
      chk("first_grant", 32'(bus_if.grant_o), 32'h1);
      acks = 0;
      cyc = 1;
      while (acks < 4 && cyc < 60) begin
         if (bus_if.req0_ack_o || bus_if.req1_ack_o) acks++;
         if (acks < 4) begin
            @(negedge clk_i);
            cyc++;
         end
      end
      chk("rr_acks", 32'(acks), 32'h4);
      chk("rr_cycles", 32'(cyc), 32'd11);
      drive(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);

      repeat (4) @(negedge clk_i);
      chk("idle_grant", 32'(bus_if.grant_o), 32'h0);
      chk("beat_q_left", 32'(beat_q.size()), 32'h0);
      chk("resp_q_left", 32'(resp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end
endmodule
